// File: rtl/uncached_dbus_bridge.sv
// Uncached dbus responder: turns one dbus request at a time into a single-beat AXI
// read (AR/R) or write (AW/W/B), answering addr_ok on accept and data_ok on completion.
package dbus_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] data;
    logic [3:0]  write_en;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4
  } bridge_state_e;
endpackage

module uncached_dbus_bridge
  import dbus_pkg::*;
#(
  parameter int                 ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  dbus_req_t           dreq,
  output dbus_resp_t          dresp,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output bridge_state_e       dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; valid and
  // payload stay constant from assertion until that edge.

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   data_q, data_d;
  logic [3:0]    wen_q, wen_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          data_ok_q, data_ok_d;
  logic          accept;
  logic          unused_ok;

  // Reset gates acceptance so addr_ok reads 0 for the whole reset window.
  assign accept = dreq.req && (state_q == S_IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      data_q      <= '0;
      wen_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      resp_data_q <= '0;
      data_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      data_q      <= data_d;
      wen_q       <= wen_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      resp_data_q <= resp_data_d;
      data_ok_q   <= data_ok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    data_d      = data_q;
    wen_d       = wen_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    resp_data_d = resp_data_q;
    data_ok_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d    = dreq.addr;
          size_d    = dreq.size;
          data_d    = dreq.data;
          wen_d     = dreq.write_en;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = dreq.is_write ? S_WR_REQ : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (rvalid) begin
          resp_data_d = rdata;
          data_ok_d   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently, in either order or together.
        aw_done_d = aw_done_q || awready;
        w_done_d  = w_done_q || wready;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bvalid) begin
          resp_data_d = '0;
          data_ok_d   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arvalid = (state_q == S_RD_ADDR);
  assign rready  = (state_q == S_RD_DATA);

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = 2'b01;
  assign awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign wdata   = data_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign bready  = (state_q == S_WR_RESP);

  assign dresp.addr_ok = accept;
  assign dresp.data_ok = data_ok_q;
  assign dresp.data    = resp_data_q;
  assign dbg_state     = state_q;

  // Response codes and rlast carry no information for single-beat uncached accesses.
  assign unused_ok = ^{rresp, rlast, bresp};
endmodule

// File: tb/tb_uncached_dbus_bridge.sv
// Bench for uncached_dbus_bridge: initiator plus randomly-delayed AXI responder, with
// a transaction-level model of the expected handshakes and returned data.
module tb_uncached_dbus_bridge;
  import dbus_pkg::*;

  logic          clk;
  logic          reset;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  logic [3:0]    arid, awid;
  logic [31:0]   araddr, awaddr, rdata, wdata;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst, rresp, bresp;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]    wstrb;
  bridge_state_e dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  uncached_dbus_bridge dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_dreq(input logic req);
    dreq.req      = req;
    dreq.addr     = $urandom;
    dreq.is_write = 1'($urandom_range(0, 1));
    dreq.size     = 2'($urandom_range(0, 2));
    dreq.data     = $urandom;
    dreq.write_en = 4'($urandom_range(0, 15));
  endtask

  task automatic drive_noise(input bit force_stray);
    rvalid  = force_stray ? 1'b1 : ($urandom_range(0, 3) == 0);
    bvalid  = force_stray ? 1'b1 : ($urandom_range(0, 3) == 0);
    rdata   = $urandom;
    rresp   = 2'($urandom_range(0, 3));
    bresp   = 2'($urandom_range(0, 3));
    rlast   = 1'($urandom_range(0, 1));
    arready = 1'($urandom_range(0, 1));
    awready = 1'($urandom_range(0, 1));
    wready  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n, input bit force_stray);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      rand_dreq(1'b0);
      drive_noise(force_stray);
      #1;
      chk("idle_addr_ok", dresp.addr_ok, 0);
      chk("idle_data_ok", dresp.data_ok, 0);
      chk("idle_outs", {arvalid, awvalid, wvalid, rready, bready}, 0);
    end
  endtask

  // One request from accept to its data_ok cycle; returns the data_ok cycle index.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                     input logic [31:0] data, input logic [3:0] wen, input logic [31:0] rdat,
                     input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                     input int b_dly, input bit hold_req, input bit b2b, output int lat);
    bit ar_done, aw_done, w_done, r_pend, b_pend, b_started, final_next, done;
    int r_cnt, b_cnt;
    dreq.req = 1'b1; dreq.addr = addr; dreq.is_write = wr; dreq.size = size;
    dreq.data = data; dreq.write_en = wen;
    drive_noise(1'b0);
    #1;
    chk("accept_addr_ok", dresp.addr_ok, 1);
    chk("accept_outs", {arvalid, awvalid, wvalid, rready, bready}, 0);
    if (!b2b) chk("accept_data_ok", dresp.data_ok, 0);
    ar_done = wr; aw_done = !wr; w_done = !wr;
    r_pend = 0; b_pend = 0; b_started = 0; final_next = 0; done = 0;
    r_cnt = 0; b_cnt = 0; lat = -1;
    for (int t = 1; t <= 200; t++) begin
      next_cycle();
      rand_dreq(final_next ? 1'b0 : (hold_req ? 1'b1 : 1'($urandom_range(0, 1))));
      drive_noise(1'b0);
      arready = (t - 1 >= ar_dly);
      awready = (t - 1 >= aw_dly);
      wready  = (t - 1 >= w_dly);
      if (r_pend) begin rvalid = (r_cnt >= r_dly); rdata = rdat; end
      if (b_pend) bvalid = (b_cnt >= b_dly);
      #1;
      chk("busy_addr_ok", dresp.addr_ok, 0);
      chk("data_ok", dresp.data_ok, final_next);
      if (final_next) begin
        chk("resp_data", dresp.data, exp_q.pop_front());
        lat = t;
        done = 1;
        break;
      end
      chk("arvalid", arvalid, !ar_done);
      if (!ar_done) begin
        chk("araddr", araddr, addr);
        chk("ar_fixed", {arid, arlen, arsize, arburst}, {4'd1, 8'd0, 1'b0, size, 2'b01});
      end
      chk("rready", rready, r_pend);
      chk("awvalid", awvalid, !aw_done);
      if (!aw_done) begin
        chk("awaddr", awaddr, addr);
        chk("aw_fixed", {awid, awlen, awsize, awburst}, {4'd1, 8'd0, 1'b0, size, 2'b01});
      end
      chk("wvalid", wvalid, !w_done);
      if (!w_done) begin
        chk("wdata", wdata, data);
        chk("wstrb_wlast", {wlast, wstrb}, {1'b1, wen});
      end
      chk("bready", bready, b_pend);
      // responder-side bookkeeping for the edge that ends this cycle
      if (r_pend) begin
        if (rvalid) begin exp_q.push_back(rdat); r_pend = 0; final_next = 1; end
        else r_cnt++;
      end
      if (!ar_done && arready) begin ar_done = 1; r_pend = 1; r_cnt = 0; end
      if (b_pend) begin
        if (bvalid) begin exp_q.push_back(32'd0); b_pend = 0; final_next = 1; end
        else b_cnt++;
      end
      if (!aw_done && awready) aw_done = 1;
      if (!w_done && wready) w_done = 1;
      if (wr && aw_done && w_done && !b_started) begin b_pend = 1; b_started = 1; b_cnt = 0; end
    end
    chk("txn_done", done, 1);
  endtask

  task automatic reset_mid_write();
    next_cycle();
    dreq.req = 1'b1; dreq.is_write = 1'b1; dreq.addr = 32'h1000_0040; dreq.size = 2'd2;
    dreq.data = 32'h1234_5678; dreq.write_en = 4'hF;
    drive_noise(1'b0);
    awready = 1'b0; wready = 1'b0;
    #1 chk("rst_accept", dresp.addr_ok, 1);
    next_cycle();
    awready = 1'b0; wready = 1'b0;
    #1 chk("rst_pre_awvalid", awvalid, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_addr_ok", dresp.addr_ok, 0);
    chk("rst_state", dbg_state, S_IDLE);
    next_cycle();
    reset = 1'b0;
    dreq.req = 1'b0;
    #1;
    chk("rst_after_outs", {arvalid, awvalid, wvalid, rready, bready, dresp.data_ok}, 0);
  endtask

  initial begin
    int  lat;
    bit  b2b;
    bit  last_txn;
    reset = 1'b1;
    rand_dreq(1'b1);
    drive_noise(1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ok_flags", {dresp.addr_ok, dresp.data_ok}, 0);
    chk("reset_data", dresp.data, 0);
    chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("reset_state", dbg_state, S_IDLE);
    @(negedge clk);
    reset = 1'b0;
    dreq.req = 1'b0;
    #1 chk("post_reset_outs", {dresp.addr_ok, dresp.data_ok, arvalid, awvalid, wvalid}, 0);

    // word read, all ready immediately
    next_cycle();
    txn(0, 32'h1FC0_0010, 2'd2, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, lat);
    chk("word_read_latency", lat, 3);
    // byte write with late B
    next_cycle();
    txn(1, 32'h1FAF_F003, 2'd0, 32'hAB00_0000, 4'b1000, 32'h0, 0, 0, 0, 0, 2, 0, 0, lat);
    // W accepted three cycles before AW
    next_cycle();
    txn(1, 32'h0000_1000, 2'd2, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 0, 3, 0, 1, 0, 0, lat);
    // stray responses while idle
    idle(3, 1'b1);
    // req held high through a slow read, then a back-to-back read
    next_cycle();
    txn(0, 32'h8000_0004, 2'd1, 32'h0, 4'h0, 32'h0BAD_F00D, 5, 1, 0, 0, 0, 1, 0, lat);
    txn(0, 32'h8000_0008, 2'd2, 32'h0, 4'h0, 32'h5555_AAAA, 0, 0, 0, 0, 0, 1, 1, lat);
    chk("b2b_latency", lat, 3);
    reset_mid_write();

    last_txn = 0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 3), 1'b0);
        last_txn = 0;
      end
      b2b = last_txn && ($urandom_range(0, 2) == 0);
      if (!b2b) next_cycle();
      txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 2)), $urandom,
          4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), b2b, lat);
      last_txn = 1;
    end
    chk("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
